pkt_sche_v0_2: RTL and testbench

Parametrised successor of the packet scheduler. Accepts packet descriptors on a single enqueue port and buffers them in one urgent FIFO plus NUM_CLASS class FIFOs. The class is taken from the descriptor's priority. Descriptors are delivered through a one-entry output register with a valid/dequeue handshake. Class arbitration is strict-priority or round-robin, selected by parameter, and a burst limit on the urgent lane prevents it from starving the class FIFOs. It sits between the priority calculator and the downstream packet-memory reader.

---
 rtl/pkt_sche_v0_2.sv | 212 +++++++++++++++++++++
 tb/tb_pkt_sche_v0_2.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_sche_v0_2.sv
// Packet scheduler: one urgent FIFO plus NUM_CLASS class FIFOs feeding a
// single output register; strict-priority or round-robin class pick.
module pkt_sche_v0_2 #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int NUM_CLASS   = 4,
  parameter int DEPTH       = 16,
  parameter int SCHED_MODE  = 0,
  parameter int URG_BURST   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  output logic                         in_ready,
  input  logic                         in_enque_en,
  input  logic                         in_ugr_en,
  input  logic [PRIOR_WIDTH-1:0]       in_prior,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_deque_en,
  output logic [DWIDTH-1:0]            out_data,
  output logic                         out_urgent,
  output logic [$clog2(NUM_CLASS)-1:0] out_class,
  output logic [15:0]                  drop_cnt
);

  localparam int CW = $clog2(NUM_CLASS);
  localparam int AW = $clog2(DEPTH);
  localparam int NF = NUM_CLASS + 1;
  localparam int IW = CW + 1;
  localparam int RW = $clog2(URG_BURST + 1);

  localparam logic [IW-1:0] URG_IDX  = IW'(NUM_CLASS);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [RW-1:0] RUN_MAX  = RW'(URG_BURST);

  logic [DWIDTH-1:0] mem_q [NF][DEPTH];

  logic [AW-1:0] wr_ptr_q [NF];
  logic [AW-1:0] wr_ptr_d [NF];
  logic [AW-1:0] rd_ptr_q [NF];
  logic [AW-1:0] rd_ptr_d [NF];
  logic [AW:0]   cnt_q    [NF];
  logic [AW:0]   cnt_d    [NF];

  logic              ready_q, ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_urgent_q, out_urgent_d;
  logic [CW-1:0]     out_class_q, out_class_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]     urg_run_q, urg_run_d;

  logic [IW-1:0] tgt;
  logic          push;
  logic [NF-1:0] ne;
  logic          any_cls;
  logic          urg_win;
  logic [CW-1:0] cls_sel;
  logic          found;
  logic [CW-1:0] rr_idx;
  logic          load;
  logic          gnt_urg;
  logic          gnt_cls;
  logic          gnt;
  logic [IW-1:0] gnt_idx;
  logic          push_i;
  logic          pop_i;
  logic          unused_prior;

  assign unused_prior = ^in_prior;

  assign ready      = ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_urgent = out_urgent_q;
  assign out_class  = out_class_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    tgt = in_ugr_en ? URG_IDX
                    : {1'b0, in_prior[PRIOR_WIDTH-1 -: CW]};
    in_ready = (cnt_q[tgt] != FULL_CNT);
    push     = in_enque_en && in_ready;

    for (int i = 0; i < NF; i++) begin
      ne[i] = (cnt_q[i] != '0);
    end
    any_cls = |ne[NUM_CLASS-1:0];
    urg_win = ne[NUM_CLASS] &&
              !((urg_run_q == RUN_MAX) && any_cls);

    // Class pick: highest index, or first at/after rr_ptr
    cls_sel = '0;
    found   = 1'b0;
    rr_idx  = '0;
    if (SCHED_MODE == 0) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (ne[i]) cls_sel = CW'(i);
      end
    end else begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        rr_idx = rr_ptr_q + CW'(k);
        if (!found && ne[rr_idx]) begin
          cls_sel = rr_idx;
          found   = 1'b1;
        end
      end
    end

    load    = !out_valid_q || out_deque_en;
    gnt_urg = load && urg_win;
    gnt_cls = load && !urg_win && any_cls;
    gnt     = gnt_urg || gnt_cls;
    gnt_idx = gnt_urg ? URG_IDX : {1'b0, cls_sel};
  end

  always_comb begin
    push_i = 1'b0;
    pop_i  = 1'b0;
    for (int i = 0; i < NF; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      push_i = push && (tgt == IW'(i));
      pop_i  = gnt && (gnt_idx == IW'(i));
      if (push_i) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop_i)  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    ready_d      = 1'b1;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_urgent_d = out_urgent_q;
    out_class_d  = out_class_q;
    drop_cnt_d   = drop_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    urg_run_d    = urg_run_q;

    if (load) begin
      out_valid_d = gnt;
      if (gnt) begin
        out_data_d   = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        out_urgent_d = gnt_urg;
        out_class_d  = gnt_urg ? '0 : cls_sel;
      end
      if (!ne[NUM_CLASS]) begin
        urg_run_d = '0;
      end else if (gnt_urg) begin
        if (urg_run_q != RUN_MAX) urg_run_d = urg_run_q + 1'b1;
      end else if (gnt_cls) begin
        urg_run_d = '0;
      end
    end

    if (gnt_cls && (SCHED_MODE != 0)) begin
      rr_ptr_d = cls_sel + 1'b1;
    end

    if (in_enque_en && !in_ready && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_urgent_q <= 1'b0;
      out_class_q  <= '0;
      drop_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      urg_run_q    <= '0;
      for (int i = 0; i < NF; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_urgent_q <= out_urgent_d;
      out_class_q  <= out_class_d;
      drop_cnt_q   <= drop_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      urg_run_q    <= urg_run_d;
      for (int i = 0; i < NF; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Storage is not cleared; pointers and counts define validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[tgt][wr_ptr_q[tgt]] <= in_data;
    end
  end

endmodule

// File: tb/tb_pkt_sche_v0_2.sv
// Directed bench for pkt_sche_v0_2: a strict-priority instance and a
// round-robin instance share one stimulus stream.
module tb_pkt_sche_v0_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_enque_en;
  logic        in_ugr_en;
  logic [5:0]  in_prior;
  logic [31:0] in_data;
  logic        out_deque_en;

  logic        o0_ready, o0_in_ready, o0_valid, o0_urgent;
  logic [31:0] o0_data;
  logic [1:0]  o0_class;
  logic [15:0] o0_drop;

  logic        o1_ready, o1_in_ready, o1_valid, o1_urgent;
  logic [31:0] o1_data;
  logic [1:0]  o1_class;
  logic [15:0] o1_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pkt_sche_v0_2 #(.SCHED_MODE(0)) u0 (
    .clk(clk), .rst(rst), .ready(o0_ready), .in_ready(o0_in_ready),
    .in_enque_en(in_enque_en), .in_ugr_en(in_ugr_en),
    .in_prior(in_prior), .in_data(in_data),
    .out_valid(o0_valid), .out_deque_en(out_deque_en),
    .out_data(o0_data), .out_urgent(o0_urgent),
    .out_class(o0_class), .drop_cnt(o0_drop)
  );

  pkt_sche_v0_2 #(.SCHED_MODE(1)) u1 (
    .clk(clk), .rst(rst), .ready(o1_ready), .in_ready(o1_in_ready),
    .in_enque_en(in_enque_en), .in_ugr_en(in_ugr_en),
    .in_prior(in_prior), .in_data(in_data),
    .out_valid(o1_valid), .out_deque_en(out_deque_en),
    .out_data(o1_data), .out_urgent(o1_urgent),
    .out_class(o1_class), .drop_cnt(o1_drop)
  );

  typedef struct {
    logic        ugr;
    logic [5:0]  prior;
    logic [31:0] data;
    logic        exp_urg;
    logic [1:0]  exp_cls;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] ed [16];
  logic [2:0]  et [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_enque_en = 1'b0;
    in_ugr_en   = 1'b0;
    in_prior    = '0;
    in_data     = '0;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic enq(input logic ugr, input logic [5:0] pr,
                     input logic [31:0] d);
    in_enque_en = 1'b1;
    in_ugr_en   = ugr;
    in_prior    = pr;
    in_data     = d;
    tick();
    idle_in();
  endtask

  // Take n outputs one per cycle and compare against ed/et
  task automatic drain(input bit rr, input int n, input string nm);
    logic        v;
    logic [31:0] d;
    logic [2:0]  t;
    out_deque_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      v = rr ? o1_valid : o0_valid;
      d = rr ? o1_data  : o0_data;
      t = rr ? {o1_urgent, o1_class} : {o0_urgent, o0_class};
      chk($sformatf("%s_valid[%0d]", nm, i), {31'd0, v}, 32'd1);
      chk($sformatf("%s_data[%0d]", nm, i), d, ed[i]);
      chk($sformatf("%s_src[%0d]", nm, i), {29'd0, t}, {29'd0, et[i]});
      tick();
    end
    out_deque_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q[$];
    int          fcnt;
    logic        ov;
    logic        req;
    logic        acc;
    int          nout;
    logic [31:0] last;

    tbl[0] = '{1'b0, 6'h3F, 32'h0000_00A5, 1'b0, 2'd3};
    tbl[1] = '{1'b0, 6'h00, 32'h1111_0000, 1'b0, 2'd0};
    tbl[2] = '{1'b0, 6'h10, 32'h2222_0001, 1'b0, 2'd1};
    tbl[3] = '{1'b0, 6'h25, 32'h3333_0002, 1'b0, 2'd2};
    tbl[4] = '{1'b1, 6'h3F, 32'h4444_0003, 1'b1, 2'd0};

    out_deque_en = 1'b0;
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_ready", {31'd0, o0_ready}, 32'd0);
    chk("rst_valid", {31'd0, o0_valid}, 32'd0);
    chk("rst_data", o0_data, 32'd0);
    chk("rst_urgent", {31'd0, o0_urgent}, 32'd0);
    chk("rst_class", {30'd0, o0_class}, 32'd0);
    chk("rst_drop", {16'd0, o0_drop}, 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, o0_ready}, 32'd1);

    // Single-descriptor latency vectors
    out_deque_en = 1'b1;
    foreach (tbl[i]) begin
      in_enque_en = 1'b1;
      in_ugr_en   = tbl[i].ugr;
      in_prior    = tbl[i].prior;
      in_data     = tbl[i].data;
      tick();
      idle_in();
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, o0_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), o0_data, tbl[i].data);
      chk($sformatf("vec%0d_cls", i), {30'd0, o0_class},
          {30'd0, tbl[i].exp_cls});
      chk($sformatf("vec%0d_urg", i), {31'd0, o0_urgent},
          {31'd0, tbl[i].exp_urg});
    end
    tick();
    chk("idle_valid_clears", {31'd0, o0_valid}, 32'd0);
    chk("latency_drop", {16'd0, o0_drop}, 32'd0);
    out_deque_en = 1'b0;

    // Strict priority; dummy occupies the output register first
    do_reset();
    enq(1'b0, 6'h3F, 32'h99);
    tick();
    enq(1'b0, 6'h00, 32'h10);
    enq(1'b0, 6'h20, 32'h20);
    enq(1'b0, 6'h10, 32'h30);
    ed[0] = 32'h99; et[0] = 3'b011;
    ed[1] = 32'h20; et[1] = 3'b010;
    ed[2] = 32'h30; et[2] = 3'b001;
    ed[3] = 32'h10; et[3] = 3'b000;
    drain(1'b0, 4, "sp");

    // Round-robin
    do_reset();
    enq(1'b0, 6'h3F, 32'h99);
    tick();
    for (int k = 0; k < 8; k++) begin
      enq(1'b0, 6'((k / 2) << 4), 32'h40 + 32'(k));
    end
    ed[0] = 32'h99; et[0] = 3'b011;
    for (int k = 0; k < 8; k++) begin
      ed[k+1] = 32'h40 + 32'(2 * (k % 4) + k / 4);
      et[k+1] = 3'(k % 4);
    end
    drain(1'b1, 9, "rr");

    // Urgent burst limit
    do_reset();
    enq(1'b0, 6'h3F, 32'h99);
    tick();
    for (int k = 0; k < 10; k++) enq(1'b1, 6'h3F, 32'h100 + 32'(k));
    for (int k = 0; k < 2; k++)  enq(1'b0, 6'h10, 32'h200 + 32'(k));
    ed[0]  = 32'h99;  et[0]  = 3'b011;
    ed[1]  = 32'h100; et[1]  = 3'b100;
    ed[2]  = 32'h101; et[2]  = 3'b100;
    ed[3]  = 32'h102; et[3]  = 3'b100;
    ed[4]  = 32'h103; et[4]  = 3'b100;
    ed[5]  = 32'h200; et[5]  = 3'b001;
    ed[6]  = 32'h104; et[6]  = 3'b100;
    ed[7]  = 32'h105; et[7]  = 3'b100;
    ed[8]  = 32'h106; et[8]  = 3'b100;
    ed[9]  = 32'h107; et[9]  = 3'b100;
    ed[10] = 32'h201; et[10] = 3'b001;
    ed[11] = 32'h108; et[11] = 3'b100;
    ed[12] = 32'h109; et[12] = 3'b100;
    drain(1'b0, 13, "burst");

    // Full, drop and pointer wrap on class 0
    do_reset();
    enq(1'b0, 6'h3F, 32'h99);
    tick();
    for (int k = 0; k < 16; k++) enq(1'b0, 6'h00, 32'h300 + 32'(k));
    in_enque_en = 1'b1;
    in_prior    = 6'h00;
    in_data     = 32'hBAD;
    #1;
    chk("full_in_ready", {31'd0, o0_in_ready}, 32'd0);
    tick();
    idle_in();
    chk("full_drop", {16'd0, o0_drop}, 32'd1);

    q.delete();
    q.push_back(32'h99);
    for (int k = 0; k < 16; k++) q.push_back(32'h300 + 32'(k));
    fcnt = 16;
    ov   = 1'b1;
    out_deque_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req = (i % 3) != 2;
      in_enque_en = req;
      in_prior    = 6'h00;
      in_data     = 32'h400 + 32'(i);
      #1;
      chk($sformatf("wrap_in_ready[%0d]", i), {31'd0, o0_in_ready},
          {31'd0, fcnt < 16});
      chk($sformatf("wrap_valid[%0d]", i), {31'd0, o0_valid},
          {31'd0, ov});
      if (ov) begin
        if (q.size() == 0) begin
          chk($sformatf("wrap_model[%0d]", i), o0_data, 32'hDEAD);
        end else begin
          chk($sformatf("wrap_data[%0d]", i), o0_data, q.pop_front());
        end
      end
      acc = req && (fcnt < 16);
      if (acc) q.push_back(32'h400 + 32'(i));
      ov   = fcnt > 0;
      fcnt = fcnt - ((fcnt > 0) ? 1 : 0) + (acc ? 1 : 0);
      tick();
    end
    idle_in();
    out_deque_en = 1'b0;

    // Reset mid-operation
    do_reset();
    for (int k = 0; k < 5; k++) enq(1'b0, 6'h20, 32'h500 + 32'(k));
    tick();
    chk("mid_pre_valid", {31'd0, o0_valid}, 32'd1);
    rst         = 1'b1;
    in_enque_en = 1'b1;
    in_prior    = 6'h00;
    in_data     = 32'hEE;
    tick();
    rst = 1'b0;
    idle_in();
    chk("mid_valid", {31'd0, o0_valid}, 32'd0);
    chk("mid_drop", {16'd0, o0_drop}, 32'd0);
    chk("mid_in_ready", {31'd0, o0_in_ready}, 32'd1);
    enq(1'b0, 6'h10, 32'h77);
    out_deque_en = 1'b1;
    nout = 0;
    last = '0;
    for (int i = 0; i < 8; i++) begin
      if (o0_valid) begin
        nout++;
        last = o0_data;
      end
      tick();
    end
    out_deque_en = 1'b0;
    chk("mid_out_count", 32'(nout), 32'd1);
    chk("mid_out_data", last, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
